// File: rtl/csi2tx_dphy_pkg.sv
// Shared definitions for the CSI-2 TX D-PHY clock-lane control logic.
package csi2tx_dphy_pkg;

  localparam logic [3:0] STOP      = 4'd0;
  localparam logic [3:0] HS_REQ    = 4'd1;
  localparam logic [3:0] HS_ON     = 4'd2;
  localparam logic [3:0] HS_HOLD   = 4'd3;
  localparam logic [3:0] HS_EXIT   = 4'd4;
  localparam logic [3:0] ULPS_ENT  = 4'd5;
  localparam logic [3:0] ULPS      = 4'd6;
  localparam logic [3:0] ULPS_EXIT = 4'd7;
  localparam logic [3:0] ULPS_DROP = 4'd8;

  typedef enum logic [3:0] {
    S_STOP      = STOP,
    S_HS_REQ    = HS_REQ,
    S_HS_ON     = HS_ON,
    S_HS_HOLD   = HS_HOLD,
    S_HS_EXIT   = HS_EXIT,
    S_ULPS_ENT  = ULPS_ENT,
    S_ULPS      = ULPS,
    S_ULPS_EXIT = ULPS_EXIT,
    S_ULPS_DROP = ULPS_DROP
  } clk_state_e;

endpackage

// File: rtl/csi2tx_dphy_sync2.sv
// Two-flop level synchroniser with asynchronous active-low reset.
module csi2tx_dphy_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/csi2tx_dphy_clk_lane_ctrl.sv
// Clock-lane sequencer: HS clock start/hold/stop and ULPS entry/exit, escape-clock domain.
module csi2tx_dphy_clk_lane_ctrl
  import csi2tx_dphy_pkg::*;
#(
  parameter int WAKEUP_W  = 20,
  parameter int TO_CYCLES = 1023
) (
  input  logic                txclkesc,
  input  logic                txescclk_rst_n,
  input  logic                cont_clk_mode,
  input  logic                data_hs_req,
  input  logic                data_lanes_stop,
  input  logic                ulps_req,
  input  logic                ulps_exit_req,
  input  logic [7:0]          clk_post_cnt,
  input  logic [WAKEUP_W-1:0] wakeup_cnt,
  input  logic                frd_sot,
  input  logic                mas_stopstate_clk,
  input  logic                ulpsactivenotclk_s,
  output logic                txrequesths_clk,
  output logic                txulpsclk,
  output logic                txulpsexit_clk,
  output logic                clk_hs_ready,
  output logic                clk_ulps_active,
  output logic                err_timeout,
  output logic [3:0]          ctrl_state
);

  localparam int CNT_W = (WAKEUP_W > 8) ? WAKEUP_W : 8;
  localparam int WD_W  = $clog2(TO_CYCLES + 1);

  clk_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             sot_sync, sot_dly_q, sot_rise;
  logic             wd_wait, wd_hit, cnt_last, cnt_dec;
  logic             req_q, req_d, ulps_q, ulps_d, uexit_q, uexit_d;
  logic             rdy_q, rdy_d, uact_q, uact_d, err_q, err_d;

  csi2tx_dphy_sync2 u_sot_sync (
    .clk   (txclkesc),
    .rst_n (txescclk_rst_n),
    .d     (frd_sot),
    .q     (sot_sync)
  );

  assign sot_rise = sot_sync & ~sot_dly_q;
  // A count of 0 or 1 both end the phase on this cycle, so a zero load acts as one.
  assign cnt_last = (cnt_q <= CNT_W'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cnt_dec = 1'b0;
    case (state_q)
      S_STOP: begin
        if (mas_stopstate_clk) begin
          if (data_hs_req || cont_clk_mode)        state_d = S_HS_REQ;
          else if (ulps_req && data_lanes_stop)    state_d = S_ULPS_ENT;
        end
      end
      S_HS_REQ: if (sot_rise) state_d = S_HS_ON;
      S_HS_ON: begin
        if (!data_hs_req && data_lanes_stop && (!cont_clk_mode || ulps_req)) begin
          state_d = S_HS_HOLD;
          cnt_d   = CNT_W'(clk_post_cnt);
        end
      end
      S_HS_HOLD: begin
        if (data_hs_req) state_d = S_HS_ON;
        else begin
          cnt_dec = 1'b1;
          if (cnt_last) state_d = S_HS_EXIT;
        end
      end
      S_HS_EXIT:   if (mas_stopstate_clk) state_d = S_STOP;
      S_ULPS_ENT:  if (!ulpsactivenotclk_s) state_d = S_ULPS;
      S_ULPS: begin
        if (ulps_exit_req) begin
          state_d = S_ULPS_EXIT;
          cnt_d   = CNT_W'(wakeup_cnt);
        end
      end
      S_ULPS_EXIT: begin
        cnt_dec = 1'b1;
        if (cnt_last) state_d = S_ULPS_DROP;
      end
      S_ULPS_DROP: if (mas_stopstate_clk) state_d = S_STOP;
      default:     state_d = S_STOP;
    endcase
    if (cnt_dec) cnt_d = (cnt_q != '0) ? cnt_q - 1'b1 : '0;

    // Watchdog restarts on expiry and on any state change; the FSM keeps waiting.
    wd_wait = state_q inside {S_HS_REQ, S_HS_EXIT, S_ULPS_ENT, S_ULPS_DROP};
    wd_hit  = wd_wait && (state_d == state_q) && (wd_q == WD_W'(TO_CYCLES - 1));
    wd_d    = (!wd_wait || (state_d != state_q) || wd_hit) ? '0 : wd_q + 1'b1;

    req_d   = state_d inside {S_HS_REQ, S_HS_ON, S_HS_HOLD};
    rdy_d   = (state_d == S_HS_ON);
    ulps_d  = state_d inside {S_ULPS_ENT, S_ULPS, S_ULPS_EXIT};
    uexit_d = (state_d == S_ULPS_EXIT);
    uact_d  = (state_d == S_ULPS);
    err_d   = wd_hit;
  end

  always_ff @(posedge txclkesc or negedge txescclk_rst_n) begin
    if (!txescclk_rst_n) begin
      state_q   <= S_STOP;
      cnt_q     <= '0;
      wd_q      <= '0;
      sot_dly_q <= 1'b0;
      req_q     <= 1'b0;
      rdy_q     <= 1'b0;
      ulps_q    <= 1'b0;
      uexit_q   <= 1'b0;
      uact_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wd_q      <= wd_d;
      sot_dly_q <= sot_sync;
      req_q     <= req_d;
      rdy_q     <= rdy_d;
      ulps_q    <= ulps_d;
      uexit_q   <= uexit_d;
      uact_q    <= uact_d;
      err_q     <= err_d;
    end
  end

  assign txrequesths_clk = req_q;
  assign clk_hs_ready    = rdy_q;
  assign txulpsclk       = ulps_q;
  assign txulpsexit_clk  = uexit_q;
  assign clk_ulps_active = uact_q;
  assign err_timeout     = err_q;
  assign ctrl_state      = state_q;

endmodule

// File: tb/tb_csi2tx_dphy_clk_lane_ctrl.sv
// Directed scenarios plus randomized traffic against a cycle-deadline reference model.
module tb_csi2tx_dphy_clk_lane_ctrl;

  localparam int TO = 16;
  localparam int WW = 20;
  localparam int M_STOP = 0, M_HREQ = 1, M_HON = 2, M_HHOLD = 3, M_HEXIT = 4;
  localparam int M_UENT = 5, M_ULPS = 6, M_UEXIT = 7, M_UDROP = 8;

  logic          gclk = 1'b0;
  logic          rst_n;
  logic          cont, hs, dls, ulps_req, uexit_req, sot, stop, uact;
  logic [7:0]    post;
  logic [WW-1:0] wake;
  logic          txrequesths_clk, txulpsclk, txulpsexit_clk, clk_hs_ready;
  logic          clk_ulps_active, err_timeout;
  logic [3:0]    ctrl_state;

  always #5 gclk = ~gclk;

  csi2tx_dphy_clk_lane_ctrl #(.WAKEUP_W(WW), .TO_CYCLES(TO)) dut (
    .txclkesc           (gclk),
    .txescclk_rst_n     (rst_n),
    .cont_clk_mode      (cont),
    .data_hs_req        (hs),
    .data_lanes_stop    (dls),
    .ulps_req           (ulps_req),
    .ulps_exit_req      (uexit_req),
    .clk_post_cnt       (post),
    .wakeup_cnt         (wake),
    .frd_sot            (sot),
    .mas_stopstate_clk  (stop),
    .ulpsactivenotclk_s (uact),
    .txrequesths_clk    (txrequesths_clk),
    .txulpsclk          (txulpsclk),
    .txulpsexit_clk     (txulpsexit_clk),
    .clk_hs_ready       (clk_hs_ready),
    .clk_ulps_active    (clk_ulps_active),
    .err_timeout        (err_timeout),
    .ctrl_state         (ctrl_state)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model: phase plus absolute cycle deadlines, sot edge from sampled history.
  int m_ph, cyc, hold_end, wake_end, wait_start;
  bit h1, h2, h3, m_err;

  task automatic m_reset();
    m_ph = M_STOP; cyc = 0; wait_start = 0; hold_end = 0; wake_end = 0;
    h1 = 0; h2 = 0; h3 = 0; m_err = 0;
  endtask

  task automatic m_step();
    int nx;
    bit sot_edge, waiting;
    sot_edge = h2 & ~h3;
    nx = m_ph;
    cyc++;
    case (m_ph)
      M_STOP:  if (stop) begin
                 if (hs || cont) nx = M_HREQ;
                 else if (ulps_req && dls) nx = M_UENT;
               end
      M_HREQ:  if (sot_edge) nx = M_HON;
      M_HON:   if (!hs && dls && (!cont || ulps_req)) begin
                 nx = M_HHOLD; hold_end = cyc + ((post == 0) ? 1 : int'(post));
               end
      M_HHOLD: if (hs) nx = M_HON; else if (cyc >= hold_end) nx = M_HEXIT;
      M_HEXIT: if (stop) nx = M_STOP;
      M_UENT:  if (!uact) nx = M_ULPS;
      M_ULPS:  if (uexit_req) begin
                 nx = M_UEXIT; wake_end = cyc + ((wake == 0) ? 1 : int'(wake));
               end
      M_UEXIT: if (cyc >= wake_end) nx = M_UDROP;
      M_UDROP: if (stop) nx = M_STOP;
      default: nx = M_STOP;
    endcase
    waiting = (m_ph == M_HREQ) || (m_ph == M_HEXIT) || (m_ph == M_UENT) || (m_ph == M_UDROP);
    m_err = waiting && (nx == m_ph) && (((cyc - wait_start) % TO) == 0);
    if (nx != m_ph) wait_start = cyc;
    m_ph = nx;
    h3 = h2; h2 = h1; h1 = sot;
  endtask

  function automatic logic [31:0] m_exp();
    logic [31:0] v;
    v = {22'd0, (m_ph >= M_HREQ && m_ph <= M_HHOLD), (m_ph >= M_UENT && m_ph <= M_UEXIT),
         (m_ph == M_UEXIT), (m_ph == M_HON), (m_ph == M_ULPS), m_err, 4'(m_ph)};
    return v;
  endfunction

  function automatic logic [31:0] dut_vec();
    return {22'd0, txrequesths_clk, txulpsclk, txulpsexit_clk, clk_hs_ready,
            clk_ulps_active, err_timeout, ctrl_state};
  endfunction

  task automatic tick();
    @(posedge gclk);
    m_step();
    #1;
    chk("outs", dut_vec(), m_exp());
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 chk("async_rst", dut_vec(), 32'd0);
    m_reset();
    @(negedge gclk) rst_n = 1'b1;
  endtask

  task automatic set_idle();
    cont = 0; hs = 0; dls = 1; ulps_req = 0; uexit_req = 0; sot = 0;
    stop = 1; uact = 1; post = 8'd5; wake = '0;
  endtask

  initial begin
    int t_rise, t_rdy, t_drop, hi, req_min, p1, p2, npul;
    bit prev_x;
    set_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge gclk);
    #1 chk("reset", dut_vec(), 32'd0);
    @(negedge gclk) rst_n = 1'b1;
    m_reset();
    repeat (3) tick();

    // Gated burst with a post-hold of 5
    hs = 1; dls = 0; t_rise = 0; t_rdy = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 11) sot = 1;
      tick();
      if (txrequesths_clk && t_rise == 0) t_rise = i;
      if (clk_hs_ready && t_rdy == 0) t_rdy = i - 10;
    end
    chk("s1_rise", t_rise, 1);
    chk("s1_rdy", (t_rdy >= 2 && t_rdy <= 3), 1);
    hs = 0; dls = 1; t_drop = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 2) post = 8'd200;
      if (!txrequesths_clk && t_drop == 0) t_drop = i;
    end
    chk("s1_drop", t_drop, 6);
    chk("s1_stop", ctrl_state, 0);

    // Re-request while holding at count 2
    sot = 0; post = 8'd5; repeat (2) tick();
    hs = 1; dls = 0;
    for (int i = 1; i <= 8; i++) begin if (i == 3) sot = 1; tick(); end
    hs = 0; dls = 1; req_min = 1;
    repeat (4) begin tick(); req_min &= int'(txrequesths_clk); end
    hs = 1; dls = 0;
    repeat (5) begin tick(); req_min &= int'(txrequesths_clk); end
    chk("s2_nodrop", req_min, 1);
    chk("s2_state", ctrl_state, 2);
    chk("s2_ready", clk_hs_ready, 1);
    hs = 0; dls = 1; repeat (10) tick();
    sot = 0;

    // Continuous clock
    cont = 1; repeat (3) tick();
    sot = 1; hi = 0;
    repeat (40) begin tick(); hi += int'(txrequesths_clk); end
    chk("s3_held", hi, 40);
    chk("s3_ready", clk_hs_ready, 1);
    cont = 0; repeat (10) tick();
    chk("s3_stop", ctrl_state, 0);
    sot = 0;

    // ULPS entry and exit with 100-cycle wake-up
    ulps_req = 1; uact = 1;
    repeat (4) tick();
    uact = 0; repeat (3) tick();
    chk("s4_ulps", clk_ulps_active, 1);
    ulps_req = 0; repeat (3) tick();
    chk("s4_stay", ctrl_state, 6);
    wake = WW'(100); uexit_req = 1; stop = 0; hi = 0; prev_x = 0;
    for (int i = 1; i <= 110; i++) begin
      tick();
      if (i == 1) uexit_req = 0;
      hi += int'(txulpsexit_clk);
      if (prev_x && !txulpsexit_clk) chk("s4_together", txulpsclk, 0);
      prev_x = txulpsexit_clk;
    end
    chk("s4_exit_len", hi, 100);
    stop = 1; uact = 1; repeat (3) tick();
    chk("s4_stop", ctrl_state, 0);

    // Watchdog while sot never arrives
    hs = 1; dls = 0; p1 = 0; p2 = 0; npul = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (err_timeout) begin
        npul++;
        if (p1 == 0) p1 = i; else if (p2 == 0) p2 = i;
      end
    end
    chk("s5_first", p1 - 1, 16);
    chk("s5_second", p2 - 1, 32);
    chk("s5_count", npul, 2);
    chk("s5_state", ctrl_state, 1);
    sot = 1; repeat (4) tick();
    hs = 0; dls = 1; repeat (10) tick();
    sot = 0;

    // Reset during ULPS exit
    ulps_req = 1; repeat (2) tick();
    uact = 0; repeat (2) tick();
    wake = WW'(1000); uexit_req = 1; repeat (20) tick();
    chk("s6_in_exit", ctrl_state, 7);
    do_reset();
    set_idle();
    repeat (5) tick();
    chk("s6_noreq", txrequesths_clk, 0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0)  hs = ~hs;
      if ($urandom_range(0, 4) == 0)  dls = ~dls;
      if ($urandom_range(0, 39) == 0) cont = ~cont;
      if ($urandom_range(0, 14) == 0) ulps_req = ~ulps_req;
      if ($urandom_range(0, 14) == 0) uexit_req = ~uexit_req;
      if ($urandom_range(0, 3) == 0)  sot = ~sot;
      stop = ($urandom_range(0, 4) != 0);
      uact = ($urandom_range(0, 2) != 0);
      post = 8'($urandom_range(0, 15));
      wake = WW'($urandom_range(0, 20));
      if ($urandom_range(0, 799) == 0) do_reset();
      else tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
